fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Parametrised instruction prefetcher that decouples memory reads from decode in the NES CPU.
- Issues wide memory reads ahead of execution into a circular byte queue.
- Presents one complete variable-length 6502 instruction per handshake: opcode, little-endian operand, length and PC.
- Sits between pc/memory and decoder_t. Replaces the fixed 3-byte fetch with PC stepping by instruction length and flush on taken branches.

Parameters:
- ADDR_W, 16, memory address width; PC width.
- MEM_BYTES, 3, bytes returned per memory read (1..4).
- DEPTH, 8, queue capacity in bytes. Power of two, at least max(3, MEM_BYTES).
- RESET_PC, 16'h0000, fetch and instruction PC after reset.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  redirect: discard queue and restart fetch at flush_pc_i
- flush_pc_i  in  ADDR_W  redirect target
- mem_req_o  out  1  read request; held until granted
- mem_addr_o  out  ADDR_W  read address, stable while mem_req_o=1
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  8*MEM_BYTES  read data; byte k (bits 8k+7:8k) is address+k
- instr_valid_o  out  1  complete instruction available
- instr_ready_i  in  1  decoder accepts instruction
- instr_opcode_o  out  8  opcode byte
- instr_operand_o  out  16  operand: len1 -> 0; len2 -> {8'h00,b1}; len3 -> {b2,b1}
- instr_len_o  out  2  instruction length, 1..3
- instr_pc_o  out  ADDR_W  address of opcode

Behaviour:
- Reset:
  - Queue empty, head=tail=count=0.
  - fetch_addr and instr_pc = RESET_PC.
  - FSM in IDLE.
  - All outputs 0.
- FSM states:
  - IDLE -> REQ when free bytes (DEPTH-count) >= MEM_BYTES.
  - REQ drives mem_req_o=1 and mem_addr_o=fetch_addr. REQ -> WAIT on mem_gnt_i.
  - WAIT: on mem_rvalid_i, push MEM_BYTES bytes at tail, fetch_addr += MEM_BYTES (wraps modulo 2^ADDR_W), -> IDLE.
  - DROP: entered when flush_i occurs in WAIT. On mem_rvalid_i the data is discarded -> IDLE. No push, no fetch_addr change.
- Maximum one outstanding read. A gnt and rvalid in the same cycle is not allowed; rvalid is at least one cycle after gnt.
- Length: len = nes_pkg::opcode_len(queue[head]). Official 6502 opcodes map to 1/2/3; unofficial opcodes map to 1.
- instr_valid_o = (count >= len) && count != 0 && !flush_i.
  - Combinational from registered queue state.
  - Head-relative bytes wrap modulo DEPTH.
- Pop on instr_valid_o && instr_ready_i:
  - head += len (mod DEPTH), count -= len.
  - instr_pc += len (mod 2^ADDR_W).
- A push and a pop in the same cycle: count = count + MEM_BYTES - len. The free-space check guarantees no overflow.
- Flush (highest priority; any state, same cycle as any event):
  - Empty the queue; fetch_addr and instr_pc = flush_pc_i.
  - REQ -> IDLE. A grant coincident with flush is treated as granted, so go to DROP.
  - WAIT -> DROP. In DROP, a further flush stays in DROP.
  - A pop coincident with flush is ignored.
  - Any rvalid coincident with flush is discarded.
- Operand byte positions beyond len are not used for output. instr_operand_o upper/lower bytes are forced to 0 as listed above.
- Outputs are stable while instr_valid_o=1 and instr_ready_i=0.
- Reset mid-read: everything returns to reset state. The memory side must also be reset.

Decomposition:
- nes_pkg adds:
  - BYTE constant (8).
  - typedef fetch_state_t {IDLE, REQ, WAIT, DROP}.
  - function opcode_len(logic [7:0]) returning logic [1:0], built from the 6502 addressing-mode table.
  - typedef instr_pkt_t {opcode, operand, len, pc}.
- Sub-module byte_ring_t(DEPTH, PUSH_BYTES=MEM_BYTES):
  - Circular byte store, head/tail/count.
  - Multi-byte push and variable-length pop (0..3).
  - Exposes 3 peek bytes at head.
- The top level holds the FSM, address/PC counters, length decode and output formatting.

Test Plan:
- Reset, RESET_PC=16'h8000, memory returns A9 05 EA at 8000, AD 34 12 at 8003 (zero wait):
  - First out: opcode A9, operand 0005, len 2, pc 8000.
  - Then EA, len 1, pc 8002.
  - Then AD, operand 1234, len 3, pc 8003.
- instr_ready_i=0 for 20 cycles with the same stream:
  - Queue fills to count=6, then mem_req_o stays 0.
  - Outputs stay A9/0005/8000.
  - Releasing ready resumes fetching.
- 3-byte instruction split across reads (DEPTH=8, stream EA EA AD | 00 C0 …):
  - instr_valid_o=0 for AD until the second read lands.
  - Then operand C000, pc base+2.
- flush_i with flush_pc_i=16'hC000 while in WAIT:
  - In-flight rvalid data is dropped.
  - Next mem_addr_o=C000.
  - The first instruction reported has pc C000.
  - No stale bytes appear.
- PC wrap: flush to FFFE, memory EA EA EA:
  - Instructions at FFFE, FFFF, 0000.
  - Next fetch address 0001.
- Coincident pop and flush: the pop is ignored, the queue is empty next cycle, instr_pc=flush_pc_i.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES CPU types: fetch FSM states, decoded instruction packet and the
// 6502 opcode-length table used by the prefetcher.
package nes_pkg;

  localparam int BYTE = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [15:0] pc;
  } instr_pkt_t;

  // Length from the official addressing-mode table; unofficial opcodes are 1 byte.
  function automatic logic [1:0] opcode_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      // immediate, zero page, zp indexed, (ind,X), (ind),Y, relative
      8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
      8'hA0, 8'hA2, 8'hC0, 8'hE0,
      8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5,
      8'h06, 8'h26, 8'h46, 8'h66, 8'h86, 8'hA6, 8'hC6, 8'hE6,
      8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4,
      8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5,
      8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6, 8'h96, 8'hB6,
      8'h94, 8'hB4,
      8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1,
      8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1,
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: len = 2'd2;
      // absolute, abs indexed, indirect jump, JSR
      8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED,
      8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'h8E, 8'hAE, 8'hCE, 8'hEE,
      8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hCC, 8'hEC, 8'h20,
      8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'h9D, 8'hBD, 8'hDD, 8'hFD,
      8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE, 8'hBE, 8'hBC,
      8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9: len = 2'd3;
      default: len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Memory read port and decoder handshake of the instruction prefetcher.
// master = prefetcher side, slave = memory/decoder environment.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = 3
);
  logic                   mem_req_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [8*MEM_BYTES-1:0] mem_rdata_i;

  logic                   instr_valid_o;
  logic                   instr_ready_i;
  logic [7:0]             instr_opcode_o;
  logic [15:0]            instr_operand_o;
  logic [1:0]             instr_len_o;
  logic [ADDR_W-1:0]      instr_pc_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_opcode_o, instr_operand_o, instr_len_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_opcode_o, instr_operand_o, instr_len_o, instr_pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_prefetch_queue_byte_ring.sv
// Circular byte store: fixed-width multi-byte push at tail, variable-length
// pop (0..3) at head, three peek bytes exposed from head.
module byte_ring_t import nes_pkg::*; #(
  parameter int DEPTH      = 8,
  parameter int PUSH_BYTES = 3
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [BYTE*PUSH_BYTES-1:0]   push_data_i,
  input  logic                         pop_i,
  input  logic [1:0]                   pop_len_i,
  output logic [2:0][BYTE-1:0]         peek_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BYTE-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: the byte array has no reset; head/tail/count alone decide which bytes are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      for (int k = 0; k < PUSH_BYTES; k++) begin
        mem_q[tail_q + PTR_W'(k)] <= push_data_i[BYTE*k +: BYTE];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PTR_W'(PUSH_BYTES);
      if (pop_i)  head_d = head_q + PTR_W'(pop_len_i);
      count_d = count_q + (push_i ? CNT_W'(PUSH_BYTES) : '0)
                        - (pop_i  ? CNT_W'(pop_len_i)  : '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      peek_o[i] = mem_q[head_q + PTR_W'(i)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: keeps a byte queue topped up with wide memory reads
// and hands the decoder one complete 6502 instruction per handshake.
module fetch_prefetch_queue import nes_pkg::*; #(
  parameter int                ADDR_W    = 16,
  parameter int                MEM_BYTES = 3,
  parameter int                DEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic [ADDR_W-1:0]     flush_pc_i,
  fetch_prefetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t         state_q, state_d;
  logic [ADDR_W-1:0]    fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
  logic [2:0][BYTE-1:0] peek;
  logic [CNT_W-1:0]     count;
  logic [1:0]           len;
  logic                 valid, has_room, push, pop;

  byte_ring_t #(
    .DEPTH      (DEPTH),
    .PUSH_BYTES (MEM_BYTES)
  ) u_ring (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clear_i     (flush_i),
    .push_i      (push),
    .push_data_i (bus.mem_rdata_i),
    .pop_i       (pop),
    .pop_len_i   (len),
    .peek_o      (peek),
    .count_o     (count)
  );

  assign len      = opcode_len(peek[0]);
  assign valid    = (count >= CNT_W'(len)) && (count != '0) && !flush_i;
  assign pop      = valid && bus.instr_ready_i;
  assign has_room = (CNT_W'(DEPTH) - count) >= CNT_W'(MEM_BYTES);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      instr_pc_q   <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_addr_d   = fetch_addr_q;
    instr_pc_d     = instr_pc_q;
    push           = 1'b0;
    bus.mem_req_o  = 1'b0;
    bus.mem_addr_o = '0;

    if (pop) instr_pc_d = instr_pc_q + ADDR_W'(len);

    case (state_q)
      IDLE: if (has_room) state_d = REQ;
      REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = fetch_addr_q;
        if (bus.mem_gnt_i) state_d = WAIT;
      end
      WAIT: if (bus.mem_rvalid_i) begin
        push         = 1'b1;
        fetch_addr_d = fetch_addr_q + ADDR_W'(MEM_BYTES);
        state_d      = IDLE;
      end
      DROP: if (bus.mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything; a read already granted must still be drained.
    if (flush_i) begin
      push         = 1'b0;
      fetch_addr_d = flush_pc_i;
      instr_pc_d   = flush_pc_i;
      case (state_q)
        REQ:     state_d = bus.mem_gnt_i    ? DROP : IDLE;
        WAIT:    state_d = bus.mem_rvalid_i ? IDLE : DROP;
        DROP:    state_d = bus.mem_rvalid_i ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.instr_valid_o   = valid;
    bus.instr_opcode_o  = '0;
    bus.instr_operand_o = '0;
    bus.instr_len_o     = '0;
    bus.instr_pc_o      = '0;
    if (valid) begin
      bus.instr_opcode_o = peek[0];
      bus.instr_len_o    = len;
      bus.instr_pc_o     = instr_pc_q;
      case (len)
        2'd2:    bus.instr_operand_o = {8'h00, peek[1]};
        2'd3:    bus.instr_operand_o = {peek[2], peek[1]};
        default: bus.instr_operand_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: behavioural memory with grant budget
// and latency knobs, scoreboard of expected instructions checked at each pop.
module tb_fetch_prefetch_queue;
  import nes_pkg::*;

  localparam int          ADDR_W    = 16;
  localparam int          MEM_BYTES = 3;
  localparam int          DEPTH     = 8;
  localparam logic [15:0] RESET_PC  = 16'h8000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;

  fetch_prefetch_queue_if #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) bus ();

  fetch_prefetch_queue #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  instr_pkt_t sb[$];
  instr_pkt_t got, exp_pkt;

  // Memory model: one outstanding read, rvalid `lat` cycles after grant.
  logic [7:0]  mem [65536];
  int          lat = 1;
  int          budget = -1;   // grants still allowed; negative means unlimited
  logic        pend = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] pend_addr = '0;
  logic        gnt_seen;
  logic [15:0] last_gnt_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_pkt_t mk(input logic [7:0] op, input logic [15:0] opnd,
                                    input logic [1:0] l, input logic [15:0] addr);
    instr_pkt_t p;
    p.opcode  = op;
    p.operand = opnd;
    p.len     = l;
    p.pc      = addr;
    return p;
  endfunction

  always @(negedge clk) begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    if (!rstn) begin
      pend = 1'b0;
    end else if (pend) begin
      if (wait_cnt <= 1) begin
        bus.mem_rvalid_i = 1'b1;
        for (int k = 0; k < MEM_BYTES; k++)
          bus.mem_rdata_i[8*k +: 8] = mem[pend_addr + 16'(k)];
        pend = 1'b0;
      end else begin
        wait_cnt--;
      end
    end else if (bus.mem_req_o && budget != 0) begin
      bus.mem_gnt_i = 1'b1;
      pend      = 1'b1;
      pend_addr = bus.mem_addr_o;
      wait_cnt  = lat;
      if (budget > 0) budget--;
    end
  end

  // Decoder-side monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rstn && bus.instr_valid_o && bus.instr_ready_i) begin
      got = mk(bus.instr_opcode_o, bus.instr_operand_o, bus.instr_len_o, bus.instr_pc_o);
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_instr: observed %h expected none", got);
      end
      if (sb.size() != 0) begin
        exp_pkt = sb.pop_front();
        check("instr", 64'(got), 64'(exp_pkt));
      end
    end
  end

  task automatic drain(input string tag, input int max);
    int n = 0;
    bus.instr_ready_i = 1'b1;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    bus.instr_ready_i = 1'b0;
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic await_grant(input int max);
    gnt_seen = 1'b0;
    for (int n = 0; n < max && !gnt_seen; n++) begin
      @(negedge clk);
      #1;
      if (bus.mem_gnt_i) begin
        gnt_seen      = 1'b1;
        last_gnt_addr = bus.mem_addr_o;
      end
    end
  endtask

  initial begin
    bus.instr_ready_i = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h05; mem[16'h8002] = 8'hEA;
    mem[16'h8003] = 8'hAD; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
    mem[16'h9000] = 8'hEA; mem[16'h9001] = 8'hEA; mem[16'h9002] = 8'hAD;
    mem[16'h9003] = 8'h00; mem[16'h9004] = 8'hC0;
    mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'h7F; mem[16'hC002] = 8'h8D;
    mem[16'hC003] = 8'h00; mem[16'hC004] = 8'h20;
    mem[16'hA000] = 8'h4C; mem[16'hA001] = 8'h00; mem[16'hA002] = 8'h80;

    // Reset state
    #7;
    check("rst_req",   64'(bus.mem_req_o), 64'd0);
    check("rst_addr",  64'(bus.mem_addr_o), 64'd0);
    check("rst_valid", 64'(bus.instr_valid_o), 64'd0);
    check("rst_instr", 64'({bus.instr_opcode_o, bus.instr_operand_o, bus.instr_len_o,
                            bus.instr_pc_o}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Decoder stalled: queue fills to 6 bytes, fetching stops, head stays put
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (c >= 10) begin
        check("stall_no_req", 64'(bus.mem_req_o), 64'd0);
        check("stall_hold", 64'({bus.instr_valid_o, bus.instr_opcode_o, bus.instr_operand_o,
                                  bus.instr_len_o, bus.instr_pc_o}),
              64'({1'b1, 8'hA9, 16'h0005, 2'd2, 16'h8000}));
      end
    end
    sb.push_back(mk(8'hA9, 16'h0005, 2'd2, 16'h8000));
    sb.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'h8002));
    sb.push_back(mk(8'hAD, 16'h1234, 2'd3, 16'h8003));
    drain("basic", 60);

    // 3-byte instruction split across two reads
    budget = 0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    flush_pc = 16'h9000;
    @(negedge clk);
    flush = 1'b0;
    budget = 1;
    sb.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'h9000));
    sb.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'h9001));
    drain("split_head", 60);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("split_wait_valid", 64'(bus.instr_valid_o), 64'd0);
    end
    budget = 1;
    sb.push_back(mk(8'hAD, 16'hC000, 2'd3, 16'h9002));
    drain("split_tail", 60);

    // Flush while a read is in flight: its data must be dropped
    lat = 4;
    budget = -1;
    await_grant(40);
    check("preflush_gnt", 64'(gnt_seen), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 16'hC000;
    lat = 1;
    @(negedge clk);
    flush = 1'b0;
    await_grant(40);
    check("flush_gnt", 64'(gnt_seen), 64'd1);
    check("flush_addr", 64'(last_gnt_addr), 64'hC000);
    sb.push_back(mk(8'hA2, 16'h007F, 2'd2, 16'hC000));
    sb.push_back(mk(8'h8D, 16'h2000, 2'd3, 16'hC002));
    drain("flush", 60);

    // Address and PC wrap at the top of memory
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 16'hFFFE;
    @(negedge clk);
    flush = 1'b0;
    await_grant(40);
    check("wrap_gnt0", 64'(gnt_seen), 64'd1);
    check("wrap_addr0", 64'(last_gnt_addr), 64'hFFFE);
    await_grant(40);
    check("wrap_gnt1", 64'(gnt_seen), 64'd1);
    check("wrap_addr1", 64'(last_gnt_addr), 64'h0001);
    sb.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'hFFFE));
    sb.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'hFFFF));
    sb.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'h0000));
    drain("wrap", 60);

    // Pop coincident with flush is ignored and the queue empties
    repeat (3) @(negedge clk);
    #1;
    check("pre_flush_valid", 64'(bus.instr_valid_o), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 16'hA000;
    bus.instr_ready_i = 1'b1;
    #1;
    check("flush_masks_valid", 64'(bus.instr_valid_o), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.instr_ready_i = 1'b0;
    #1;
    check("empty_after_flush", 64'(bus.instr_valid_o), 64'd0);
    sb.push_back(mk(8'h4C, 16'h8000, 2'd3, 16'hA000));
    drain("pop_flush", 60);

    // Reset in the middle of a read restarts from RESET_PC
    lat = 4;
    await_grant(40);
    check("prereset_gnt", 64'(gnt_seen), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midreset_req", 64'(bus.mem_req_o), 64'd0);
    check("midreset_valid", 64'(bus.instr_valid_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    lat = 1;
    await_grant(40);
    check("postreset_gnt", 64'(gnt_seen), 64'd1);
    check("postreset_addr", 64'(last_gnt_addr), 64'(RESET_PC));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
